crc32_stream_engine: RTL and testbench
======================================

# crc32_stream_engine

Parametrised, handshaked successor to the team's byte-serial table-driven CRC-32 engine. Accepts beats of DATA_BYTES bytes with a per-byte keep mask and frame delimiters, folds kept bytes into a running CRC one byte per cycle, and emits a registered per-frame result pulse. It sits between the packet datapath and the checksum insert/check logic. The lookup table is generated from POLY at elaboration, so no external hex file is loaded.

## Interface
- DATA_BYTES, 8: bytes per input beat; legal range is 1..16.
- POLY, 32'h04C11DB7: generator polynomial in MSB-first, non-reflected form.
- INIT, 32'hFFFFFFFF: CRC value loaded at reset and on in_sof.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  8*DATA_BYTES  beat data; byte i is in_data[8i+7:8i].
- in_keep  in  DATA_BYTES  per-byte enable; any pattern is legal.
- in_sof  in  1  first beat of frame; CRC reinitialises to INIT before this beat's bytes.
- in_eof  in  1  last beat of frame; a result follows.
- seed_load  in  1  load seed_data into the running CRC; honoured in IDLE only.
- seed_data  in  32  seed value.
- crc_out  out  32  registered frame result.
- crc_valid  out  1  one-cycle pulse; crc_out is valid while it is high.
- busy  out  1  high when the state is not IDLE.

## Operation
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) && !seed_load. This is combinational from the state register and seed_load.
- IDLE, seed_load=1: crc <= seed_data. No beat is accepted in that cycle. seed_load outside IDLE is ignored.
- IDLE, beat accepted:
  - Latch in_data, in_keep into mask, and in_eof.
  - If in_sof, crc <= INIT.
  - Next state is RUN if in_keep!=0, else DONE if in_eof, else IDLE.
- RUN:
  - Each cycle, take the lowest set bit k of mask and clear it.
  - Update crc <= {crc[23:0],8'h00} ^ T[crc[31:24] ^ byte_k], where T[j] is the 32-bit table entry for POLY.
  - When the last set bit is consumed, the next state is DONE if eof is latched, else IDLE.
- DONE: crc_out <= final(crc), crc_valid <= 1 for exactly one cycle, then IDLE.
  - The running crc is left unchanged. A following frame without in_sof continues from it.
- Kept bytes are always processed in ascending lane order. Unkept lanes cost no cycles.
- All arithmetic is 32-bit. Table index is 8-bit.
- Reset values: state=IDLE, crc=INIT, mask=0, crc_out=32'h0, crc_valid=0, busy=0.
  - in_ready is 1 after reset when seed_load=0.
- Reset mid-frame aborts the frame with no crc_valid. The partial CRC is discarded.

## Timing
- Beat accepted at cycle T with N kept bytes, N>=1:
  - RUN during T+1..T+N; crc is updated at the end of each of those cycles.
  - Non-eof: in_ready is high again at T+N+1.
  - Eof: DONE at T+N+1, crc_valid high at T+N+2, in_ready high at T+N+2.
- Zero-keep eof beat at T: crc_valid at T+2. Zero-keep non-eof beat: in_ready high at T+1.
- Throughput is 1 byte per cycle plus 1 cycle per beat, plus 1 cycle per frame.
- crc_valid and crc_out change only on clk.

## Configuration
- CRC_XOROUT_EN defined: final(crc) = crc ^ 32'hFFFFFFFF. This gives CRC-32/BZIP2 with default parameters.
- CRC_XOROUT_EN undefined: final(crc) = crc. This gives CRC-32/MPEG-2 with default parameters.
- The running crc and seed semantics are identical in both builds.

## Test plan
- Single frame, macro off, DATA_BYTES=8:
  - Stimulus: beat 1 is "12345678" (byte0='1'), keep=8'hFF, sof=1. Beat 2 is '9' in lane 0, keep=8'h01, eof=1.
  - Required: one crc_valid pulse with crc_out=32'h0376E6E7. With CRC_XOROUT_EN the result is 32'hFC891918.
- Latency:
  - Stimulus: one beat with keep=8'hFF, sof=eof=1, accepted at T.
  - Required: busy high T+1..T+9; crc_valid exactly at T+10; in_ready low T+1..T+9 and high at T+10.
- Sparse keep:
  - Stimulus: "1234" in lanes 0,2,5,7 with keep=8'hA5, then "56789" in lanes 1,3,4,6,7 with keep=8'hDA and eof.
  - Required: crc_out=32'h0376E6E7 (macro off); first beat occupies 4 RUN cycles.
- Empty frame and seed:
  - Stimulus: zero-keep beat with sof=eof=1.
  - Required: crc_out=32'hFFFFFFFF (macro off).
  - Then seed_load=1 with seed_data=32'h12345678 in IDLE, followed by a zero-keep eof beat without sof.
  - Required: crc_out=32'h12345678, and in_ready=0 during the seed_load cycle.
- Back-pressure and reset:
  - Stimulus: hold in_valid through RUN.
  - Required: no second beat accepted until in_ready rises.
  - Stimulus: assert reset_n=0 mid-RUN.
  - Required: busy, crc_valid and crc_out go to 0 immediately with no pulse; the next sof frame of "123456789" still yields 32'h0376E6E7.

Source files
------------

// File: rtl/crc32_stream_engine.sv
// crc32_stream_engine: handshaked byte-serial CRC-32 over keep-masked beats, table built from POLY.
// Define CRC_XOROUT_EN to XOR the frame result with 32'hFFFFFFFF (BZIP2 instead of MPEG-2).
module crc32_stream_engine #(
  parameter int          DATA_BYTES = 8,
  parameter logic [31:0] POLY       = 32'h04C11DB7,
  parameter logic [31:0] INIT       = 32'hFFFFFFFF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [DATA_BYTES-1:0]   in_keep,
  input  logic                    in_sof,
  input  logic                    in_eof,
  input  logic                    seed_load,
  input  logic [31:0]             seed_data,
  output logic [31:0]             crc_out,
  output logic                    crc_valid,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [31:0] tbl_entry(input logic [7:0] j);
    logic [31:0] c;
    c = {j, 24'h0};
    for (int b = 0; b < 8; b++) c = c[31] ? {c[30:0], 1'b0} ^ POLY : {c[30:0], 1'b0};
    return c;
  endfunction
  logic [31:0] tbl [256];
  for (genvar t = 0; t < 256; t++) begin : g_tbl
    assign tbl[t] = tbl_entry(8'(t));
  end
  state_t                  state;
  logic [31:0]             crc, crc_next, crc_final;
  logic [DATA_BYTES-1:0]   mask, mask_next;
  logic [8*DATA_BYTES-1:0] data;
  logic                    eof;
  logic [7:0]              cur_byte;
  // Lowest set lane wins, so kept bytes fold in ascending lane order.
  always_comb begin
    cur_byte = 8'h00;
    for (int i = DATA_BYTES - 1; i >= 0; i--) if (mask[i]) cur_byte = data[8*i +: 8];
  end
  assign mask_next = mask & (mask - DATA_BYTES'(1));
  assign crc_next  = {crc[23:0], 8'h00} ^ tbl[crc[31:24] ^ cur_byte];
`ifdef CRC_XOROUT_EN
  assign crc_final = crc ^ 32'hFFFFFFFF;
`else
  assign crc_final = crc;
`endif
  assign in_ready = (state == IDLE) && !seed_load;
  assign busy     = state != IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      crc       <= INIT;
      mask      <= '0;
      data      <= '0;
      eof       <= 1'b0;
      crc_out   <= 32'h0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (seed_load) crc <= seed_data;
          else if (in_valid) begin
            data  <= in_data;
            mask  <= in_keep;
            eof   <= in_eof;
            crc   <= in_sof ? INIT : crc;
            state <= |in_keep ? RUN : in_eof ? DONE : IDLE;
          end
        end
        RUN: begin
          crc   <= crc_next;
          mask  <= mask_next;
          state <= mask_next != '0 ? RUN : eof ? DONE : IDLE;
        end
        DONE: begin
          crc_out   <= crc_final;
          crc_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc32_stream_engine.sv
// tb_crc32_stream_engine: directed vectors for crc32_stream_engine with DATA_BYTES=8.
module tb_crc32_stream_engine;
`ifdef CRC_XOROUT_EN
  localparam logic [31:0] XO = 32'hFFFFFFFF;
`else
  localparam logic [31:0] XO = 32'h0;
`endif
  logic        clk, reset_n, in_valid, in_ready, in_sof, in_eof, seed_load, crc_valid, busy;
  logic [63:0] in_data;
  logic [7:0]  in_keep;
  logic [31:0] seed_data, crc_out;
  int total = 0, bad = 0, acc = 0, pulses = 0;
  crc32_stream_engine dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_keep(in_keep), .in_sof(in_sof), .in_eof(in_eof),
    .seed_load(seed_load), .seed_data(seed_data), .crc_out(crc_out),
    .crc_valid(crc_valid), .busy(busy)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) if (reset_n && in_valid && in_ready) acc++;
  always @(negedge clk) if (crc_valid) pulses++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Called at a negedge; returns at the negedge after acceptance with in_valid dropped.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic s, input logic e, output int w);
    in_data = d; in_keep = k; in_sof = s; in_eof = e; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask
  task automatic wait_crc(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!crc_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!crc_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else chk(tag, crc_out, exp);
    @(negedge clk);
    chk({tag, "_pulse_width"}, {31'd0, crc_valid}, 32'd0);
  endtask
  initial begin
    int w, bc, vat, rat, a0, p0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '0; in_sof = 1'b0; in_eof = 1'b0;
    seed_load = 1'b0; seed_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, crc_valid}, 32'd0);
    chk("rst_crc_out", crc_out, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    // "123456789" split 8 + 1
    send_beat(64'h3837363534333231, 8'hFF, 1'b1, 1'b0, w);
    send_beat(64'h0000000000000039, 8'h01, 1'b0, 1'b1, w);
    chk("single_wait", w, 32'd8);
    wait_crc("single", 32'h0376E6E7 ^ XO);
    // latency of a full single-beat frame
    send_beat(64'h3837363534333231, 8'hFF, 1'b1, 1'b1, w);
    bc = 0; vat = 0; rat = 0;
    for (int i = 1; i <= 10; i++) begin
      if (busy) bc++;
      if (crc_valid) vat = i;
      if (in_ready && rat == 0) rat = i;
      @(negedge clk);
    end
    chk("lat_busy", bc, 32'd9);
    chk("lat_valid", vat, 32'd10);
    chk("lat_ready", rat, 32'd10);
    // sparse keep with junk in unkept lanes
    send_beat(64'h34AA33AAAA32AA31, 8'hA5, 1'b1, 1'b0, w);
    send_beat(64'h3938AA3736AA35AA, 8'hDA, 1'b0, 1'b1, w);
    chk("sparse_wait", w, 32'd4);
    wait_crc("sparse", 32'h0376E6E7 ^ XO);
    // empty frame, then seed
    send_beat(64'h0, 8'h00, 1'b1, 1'b1, w);
    wait_crc("empty", 32'hFFFFFFFF ^ XO);
    seed_load = 1'b1; seed_data = 32'h12345678;
    #1 chk("seed_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    seed_load = 1'b0;
    send_beat(64'h0, 8'h00, 1'b0, 1'b1, w);
    wait_crc("seed", 32'h12345678 ^ XO);
    // back-pressure: second beat held until ready
    a0 = acc;
    send_beat(64'h3837363534333231, 8'hFF, 1'b1, 1'b0, w);
    in_valid = 1'b1; in_data = 64'h39; in_keep = 8'h01; in_eof = 1'b1;
    repeat (4) @(negedge clk);
    chk("bp_accepts_mid", acc - a0, 32'd1);
    send_beat(64'h39, 8'h01, 1'b0, 1'b1, w);
    chk("bp_accepts", acc - a0, 32'd2);
    wait_crc("bp", 32'h0376E6E7 ^ XO);
    // reset mid-RUN aborts the frame
    p0 = pulses;
    send_beat(64'h3837363534333231, 8'hFF, 1'b1, 1'b1, w);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, crc_valid}, 32'd0);
    chk("abort_crc_out", crc_out, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_pulse", pulses - p0, 32'd0);
    send_beat(64'h3837363534333231, 8'hFF, 1'b1, 1'b0, w);
    send_beat(64'h39, 8'h01, 1'b0, 1'b1, w);
    wait_crc("after_reset", 32'h0376E6E7 ^ XO);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
